tl_frag_ctrl: RTL and testbench

Read-side controller for the TL TX fragmentation buffer. It takes one complete TLP at a time from the buffer and cuts it into fixed-width fragments for the data link layer. Each fragment carries start/end-of-packet markers and a valid-DW count. Backpressure uses a valid/ready handshake toward the link layer, with a 2-entry output queue so the buffer's one-cycle read latency does not cost throughput.

---
 rtl/tl_frag_ctrl_if.sv | 25 ++
 rtl/tl_frag_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_tl_frag_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_frag_ctrl_if.sv
// Fragment stream toward the data link layer: payload, sop/eop markers, valid-DW count.
// Latency: none, a plain bundle of wires shared by producer and consumer.
// Backpressure: valid/ready; master holds data and flags stable until frag_ready is seen.
interface tl_frag_ctrl_if #(
    parameter int FRAG_DW = 8
);
    localparam int CW = $clog2(FRAG_DW) + 1;

    logic [FRAG_DW*32-1:0] frag_data;
    logic                  frag_valid;
    logic                  frag_ready;
    logic                  frag_sop;
    logic                  frag_eop;
    logic [CW-1:0]         frag_dw_cnt;

    modport master (
        output frag_data, frag_valid, frag_sop, frag_eop, frag_dw_cnt,
        input  frag_ready
    );

    modport slave (
        input  frag_data, frag_valid, frag_sop, frag_eop, frag_dw_cnt,
        output frag_ready
    );
endinterface

// File: rtl/tl_frag_ctrl.sv
// Read-side controller of the TL TX fragmentation buffer: cuts one TLP into FRAG_DW-DW fragments.
// Latency: buf_ready sampled at t -> first buf_rd_en at t+1 -> first frag_valid at t+2.
// Backpressure: valid/ready with a 2-entry output queue; reads issue only when a queue slot is guaranteed.
// Optional: define TL_FRAG_CTRL_STATS_EN to add the saturating tlp_sent_cnt_o counter.
module tl_frag_ctrl #(
    parameter int FRAG_DW = 8,
    parameter int LEN_W   = 11
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   buf_ready_i,
    input  logic [LEN_W-1:0]       buf_tlp_len_i,
    output logic                   buf_rd_en_o,
    input  logic [FRAG_DW*32-1:0]  buf_rd_data_i,
    output logic                   buf_release_o,
    output logic                   err_len_o,
    tl_frag_ctrl_if.master         frag
`ifdef TL_FRAG_CTRL_STATS_EN
    ,
    output logic [15:0]            tlp_sent_cnt_o
`endif
);
    localparam int CW     = $clog2(FRAG_DW) + 1;
    localparam int DATA_W = FRAG_DW * 32;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              sop;
        logic              eop;
        logic [CW-1:0]     cnt;
    } frag_t;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_RELEASE, ST_DROP} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  nfrag_q, nfrag_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;

    // Flags of the read issued last cycle; they meet the buffer data one cycle later.
    logic              infl_vld_q;
    logic              infl_sop_q, infl_eop_q;
    logic [CW-1:0]     infl_cnt_q;

    frag_t             q_mem_q [0:1];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        occ_q;

    logic [LEN_W-1:0]  len_round, nfrag_calc, len_rem;
    logic [CW-1:0]     last_cnt;
    logic              iss_sop, iss_eop;
    logic [CW-1:0]     iss_cnt;
    frag_t             infl_frag, head;
    logic              head_vld, pop, q_pop, push, credit_ok;

    // Fragment count, last-fragment DW count and flags of the read about to be issued.
    always_comb begin
        len_round  = buf_tlp_len_i + LEN_W'(FRAG_DW - 1);
        nfrag_calc = len_round / LEN_W'(FRAG_DW);
        len_rem    = len_q % LEN_W'(FRAG_DW);
        last_cnt   = (len_rem == '0) ? CW'(FRAG_DW) : CW'(len_rem);
        iss_sop    = (rd_cnt_q == '0);
        iss_eop    = (rd_cnt_q == nfrag_q - LEN_W'(1));
        iss_cnt    = iss_eop ? last_cnt : CW'(FRAG_DW);
    end

    // Queue head falls through to the arriving read data when the queue is empty; trailing DWs zeroed.
    always_comb begin
        infl_frag.dat = buf_rd_data_i;
        infl_frag.sop = infl_sop_q;
        infl_frag.eop = infl_eop_q;
        infl_frag.cnt = infl_cnt_q;
        for (int i = 0; i < FRAG_DW; i++) begin
            if (i >= int'(infl_cnt_q)) infl_frag.dat[i*32 +: 32] = '0;
        end
        head      = (occ_q != 2'd0) ? q_mem_q[rd_ptr_q] : infl_frag;
        head_vld  = (occ_q != 2'd0) || infl_vld_q;
        pop       = head_vld && frag.frag_ready;
        q_pop     = pop && (occ_q != 2'd0);
        push      = infl_vld_q && !((occ_q == 2'd0) && pop);
        credit_ok = ({1'b0, occ_q} + {2'b0, infl_vld_q}) < (3'd2 + {2'b0, pop});
    end

    // Drive the fragment interface; everything reads as zero while nothing is valid.
    always_comb begin
        frag.frag_valid  = head_vld;
        frag.frag_data   = head_vld ? head.dat : '0;
        frag.frag_sop    = head_vld && head.sop;
        frag.frag_eop    = head_vld && head.eop;
        frag.frag_dw_cnt = head_vld ? head.cnt : '0;
    end

    // FSM next state and buffer-side strobes.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        nfrag_d       = nfrag_q;
        rd_cnt_d      = rd_cnt_q;
        buf_rd_en_o   = 1'b0;
        buf_release_o = 1'b0;
        err_len_o     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (buf_ready_i) begin
                    len_d    = buf_tlp_len_i;
                    nfrag_d  = nfrag_calc;
                    rd_cnt_d = '0;
                    state_d  = (buf_tlp_len_i == '0) ? ST_DROP : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if ((rd_cnt_q < nfrag_q) && credit_ok) begin
                    buf_rd_en_o = 1'b1;
                    rd_cnt_d    = rd_cnt_q + LEN_W'(1);
                end
                if (pop && head.eop) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                buf_release_o = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_DROP: begin
                buf_release_o = 1'b1;
                err_len_o     = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (arst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // TLP bookkeeping and in-flight read tracking; reset drops any pending read.
    always_ff @(posedge clk) begin
        if (arst) begin
            len_q      <= '0;
            nfrag_q    <= '0;
            rd_cnt_q   <= '0;
            infl_vld_q <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
            infl_cnt_q <= '0;
        end else begin
            len_q      <= len_d;
            nfrag_q    <= nfrag_d;
            rd_cnt_q   <= rd_cnt_d;
            infl_vld_q <= buf_rd_en_o;
            infl_sop_q <= iss_sop;
            infl_eop_q <= iss_eop;
            infl_cnt_q <= iss_cnt;
        end
    end

    // Two-entry output queue; only occupancy and pointers need reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                q_mem_q[wr_ptr_q] <= infl_frag;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (q_pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, q_pop};
        end
    end

`ifdef TL_FRAG_CTRL_STATS_EN
    logic [15:0] tlp_sent_q;

    // Count completed TLPs at their eop handshake, saturating.
    always_ff @(posedge clk) begin
        if (arst)                                          tlp_sent_q <= '0;
        else if (pop && head.eop && tlp_sent_q != 16'hFFFF) tlp_sent_q <= tlp_sent_q + 16'd1;
    end

    assign tlp_sent_cnt_o = tlp_sent_q;
`endif
endmodule

// File: tb/tb_tl_frag_ctrl.sv
// Directed bench for tl_frag_ctrl with FRAG_DW=8: buffer model, handshake monitor, hand-computed expectations.
// Latency: checks first fragment at t+2 after buf_ready sampled at t and release one cycle after eop.
// Backpressure: drives frag_ready patterns and checks stall stability and outstanding-read bound.
module tb_tl_frag_ctrl;
    localparam int FRAG_DW = 8;
    localparam int LEN_W   = 11;

    logic               clk = 1'b0;
    logic               arst = 1'b1;
    logic               buf_ready = 1'b0;
    logic [LEN_W-1:0]   buf_tlp_len = '0;
    logic               buf_rd_en;
    logic [255:0]       buf_rd_data = '0;
    logic               buf_release;
    logic               err_len;
`ifdef TL_FRAG_CTRL_STATS_EN
    logic [15:0]        tlp_sent_cnt;
`endif

    tl_frag_ctrl_if #(.FRAG_DW(FRAG_DW)) fi ();

    tl_frag_ctrl #(.FRAG_DW(FRAG_DW), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .arst          (arst),
        .buf_ready_i   (buf_ready),
        .buf_tlp_len_i (buf_tlp_len),
        .buf_rd_en_o   (buf_rd_en),
        .buf_rd_data_i (buf_rd_data),
        .buf_release_o (buf_release),
        .err_len_o     (err_len),
        .frag          (fi.master)
`ifdef TL_FRAG_CTRL_STATS_EN
        ,
        .tlp_sent_cnt_o(tlp_sent_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int gidx  = 0;
    bit bp_en = 1'b0;

    logic [255:0] hs_dat [128];
    logic [5:0]   hs_flg [128];
    int           hs_cyc [128];
    int           hs_n = 0;
    int           rel_cyc [16];
    int           rel_n = 0;
    int           err_cyc = -1;
    int           err_n = 0;
    int           vld_cycles = 0;
    int           issued = 0, accepted = 0, max_out = 0;

    task automatic chk(string tag, logic [263:0] act, logic [263:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_dw(int g, int j);
        return 32'hA500_0000 | 32'(g << 8) | 32'(j);
    endfunction

    function automatic logic [255:0] exp_frag(int g, int c);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < FRAG_DW; j++) if (j < c) v[j*32 +: 32] = exp_dw(g, j);
        return v;
    endfunction

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Buffer model: data for a read appears one cycle after buf_rd_en, garbage otherwise.
    initial begin
        bit pend;
        forever begin
            @(negedge clk);
            pend = buf_rd_en;
            @(posedge clk);
            #1;
            if (pend) begin
                for (int j = 0; j < FRAG_DW; j++) buf_rd_data[j*32 +: 32] = exp_dw(gidx, j);
                gidx++;
            end else begin
                buf_rd_data = {8{32'hDEAD_BEEF}};
            end
        end
    end

    // Ready driver: 1,0,0,1 pattern under backpressure, otherwise always ready.
    initial forever begin
        fi.frag_ready = bp_en ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        @(posedge clk);
        #1;
    end

    // Monitor: handshakes, stall stability, releases, errors, outstanding reads.
    initial begin
        bit           prev_stall = 1'b0;
        logic [261:0] prev_v = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_vld", 264'(fi.frag_valid), 264'(1));
                chk("stall_dat", 264'({fi.frag_data, fi.frag_sop, fi.frag_eop, fi.frag_dw_cnt}), 264'(prev_v));
            end
            prev_stall = fi.frag_valid && !fi.frag_ready;
            prev_v     = {fi.frag_data, fi.frag_sop, fi.frag_eop, fi.frag_dw_cnt};
            if (buf_rd_en) issued++;
            if (fi.frag_valid && fi.frag_ready && hs_n < 128) begin
                hs_dat[hs_n] = fi.frag_data;
                hs_flg[hs_n] = {fi.frag_sop, fi.frag_eop, fi.frag_dw_cnt};
                hs_cyc[hs_n] = cyc;
                hs_n++;
                accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (buf_release && rel_n < 16) begin rel_cyc[rel_n] = cyc; rel_n++; end
            if (err_len) begin err_cyc = cyc; err_n++; end
            if (fi.frag_valid) vld_cycles++;
        end
    end

    task automatic send(int len, output int t0, output int g0);
        @(posedge clk); #1;
        g0 = gidx;
        buf_ready = 1'b1;
        buf_tlp_len = LEN_W'(len);
        t0 = cyc;
        @(posedge clk); #1;
        buf_ready = 1'b0;
    endtask

    task automatic wait_rel(int target);
        for (int i = 0; i < 200 && rel_n < target; i++) begin @(negedge clk); #1; end
        chk("rel_wait", 264'(rel_n >= target), 264'(1));
        repeat (2) @(posedge clk);
    endtask

    task automatic check_tlp(string nm, int len, int first, int g0, int t_first);
        int n, c;
        n = (len + FRAG_DW - 1) / FRAG_DW;
        for (int k = 0; k < n; k++) begin
            c = (k == n - 1) ? ((len % FRAG_DW == 0) ? FRAG_DW : len % FRAG_DW) : FRAG_DW;
            chk($sformatf("%s_dat%0d", nm, k), 264'(hs_dat[first+k]), 264'(exp_frag(g0 + k, c)));
            chk($sformatf("%s_flg%0d", nm, k), 264'(hs_flg[first+k]), 264'({k == 0, k == n - 1, 4'(c)}));
            if (t_first >= 0) chk($sformatf("%s_cyc%0d", nm, k), 264'(hs_cyc[first+k]), 264'(t_first + k));
        end
    endtask

    task automatic check_idle_outputs(string nm);
        chk({nm, "_rd_en"},   264'(buf_rd_en),       264'(0));
        chk({nm, "_release"}, 264'(buf_release),     264'(0));
        chk({nm, "_err"},     264'(err_len),         264'(0));
        chk({nm, "_valid"},   264'(fi.frag_valid),   264'(0));
        chk({nm, "_sop_eop"}, 264'({fi.frag_sop, fi.frag_eop}), 264'(0));
        chk({nm, "_data"},    264'(fi.frag_data),    264'(0));
        chk({nm, "_dwcnt"},   264'(fi.frag_dw_cnt),  264'(0));
`ifdef TL_FRAG_CTRL_STATS_EN
        chk({nm, "_sent"},    264'(tlp_sent_cnt),    264'(0));
`endif
    endtask

    initial begin
        int t0, g0, first, r0, v0, e0;
        int tests [3] = '{20, 16, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst");
        @(posedge clk); #1;
        arst = 1'b0;

        // Single TLPs with frag_ready=1: consecutive fragments, release one cycle after eop.
        foreach (tests[i]) begin
            first = hs_n; r0 = rel_n;
            send(tests[i], t0, g0);
            wait_rel(r0 + 1);
            chk($sformatf("len%0d_nfrag", tests[i]), 264'(hs_n - first), 264'((tests[i] + 7) / 8));
            check_tlp($sformatf("len%0d", tests[i]), tests[i], first, g0, t0 + 2);
            chk($sformatf("len%0d_relcyc", tests[i]), 264'(rel_cyc[r0]), 264'(hs_cyc[hs_n-1] + 1));
        end

        // Backpressure: len=32 with ready toggling 1,0,0,1.
        max_out = 0;
        bp_en = 1'b1;
        first = hs_n; r0 = rel_n;
        send(32, t0, g0);
        wait_rel(r0 + 1);
        bp_en = 1'b0;
        chk("bp_nfrag", 264'(hs_n - first), 264'(4));
        check_tlp("bp", 32, first, g0, -1);
        chk("bp_outstd_le2", 264'(max_out <= 2), 264'(1));

        // Zero length: err_len with release, no fragment; then len=4 streams normally.
        first = hs_n; r0 = rel_n; v0 = vld_cycles; e0 = err_n;
        send(0, t0, g0);
        wait_rel(r0 + 1);
        chk("zero_err_n",   264'(err_n - e0), 264'(1));
        chk("zero_err_cyc", 264'(err_cyc), 264'(rel_cyc[r0]));
        chk("zero_rel_cyc", 264'(rel_cyc[r0]), 264'(t0 + 1));
        chk("zero_no_vld",  264'(vld_cycles - v0), 264'(0));
        first = hs_n; r0 = rel_n;
        send(4, t0, g0);
        wait_rel(r0 + 1);
        chk("len4_nfrag", 264'(hs_n - first), 264'(1));
        check_tlp("len4", 4, first, g0, t0 + 2);

        // Reset mid-stream after the first of four fragments.
        first = hs_n; r0 = rel_n;
        send(32, t0, g0);
        for (int i = 0; i < 50 && hs_n <= first; i++) begin @(negedge clk); #1; end
        arst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        arst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_nfrag", 264'(hs_n - first), 264'(1));
        chk("midrst_norel", 264'(rel_n - r0), 264'(0));

        // Back-to-back: len 9 then len 3, second TLP read at the earliest slot.
        first = hs_n; r0 = rel_n;
        @(posedge clk); #1;
        g0 = gidx; t0 = cyc;
        buf_ready = 1'b1; buf_tlp_len = LEN_W'(9);
        @(posedge clk); #1;
        buf_tlp_len = LEN_W'(3);
        for (int i = 0; i < 50 && hs_n < first + 3; i++) begin @(negedge clk); #1; end
        buf_ready = 1'b0;
        wait_rel(r0 + 2);
        chk("b2b_nfrag", 264'(hs_n - first), 264'(3));
        check_tlp("b2b_a", 9, first, g0, t0 + 2);
        check_tlp("b2b_b", 3, first + 2, g0 + 2, rel_cyc[r0] + 3);
        chk("b2b_rel_a", 264'(rel_cyc[r0]), 264'(hs_cyc[first+1] + 1));
        chk("b2b_rel_b", 264'(rel_cyc[r0+1]), 264'(hs_cyc[first+2] + 1));
`ifdef TL_FRAG_CTRL_STATS_EN
        chk("b2b_sent", 264'(tlp_sent_cnt), 264'(2));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
